// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave
// Target-side JTAG Test Access Port. Holds the 16-state TAP controller,
// the instruction register, and the BYPASS, IDCODE and USER data registers.
//
// Ports:
//   tck  - test clock; every state update happens on its rising edge
//   trst - synchronous active-low test reset
//   tdi  - serial data in, sampled on rising tck
//   tms  - mode select, sampled on rising tck
//   tdo  - serial data out; combinational from the current state and registers
//
// State table:
//   TLR      | test-logic-reset, IR forced to IDCODE
//   RTI      | run-test/idle
//   SEL_DR   | select DR scan
//   CAP_DR   | capture selected data register
//   SH_DR    | shift selected data register
//   EX1_DR   | exit1 DR
//   PAUSE_DR | pause DR, shift registers held
//   EX2_DR   | exit2 DR
//   UPD_DR   | update DR (USER update register only)
//   SEL_IR   | select IR scan
//   CAP_IR   | capture 0001 into IR shift register
//   SH_IR    | shift IR shift register
//   EX1_IR   | exit1 IR
//   PAUSE_IR | pause IR
//   EX2_IR   | exit2 IR
//   UPD_IR   | update IR from shift register
module jtag_tap_slave #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5001,
  parameter int          USER_WIDTH = 32
) (
  input  logic tck,
  input  logic trst,
  input  logic tdi,
  input  logic tms,
  output logic tdo
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_t;

  localparam logic [IR_WIDTH-1:0] IR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] IR_USER   = IR_WIDTH'(2);

  state_t                state;
  logic [IR_WIDTH-1:0]   ir;
  logic [IR_WIDTH-1:0]   ir_sr;
  logic                  bypass_sr;
  logic [31:0]           id_sr;
  logic [USER_WIDTH-1:0] user_sr;
  logic [USER_WIDTH-1:0] user_reg;

  // Anything that is not IDCODE or USER (including 1111) routes through BYPASS.
  logic sel_idcode;
  logic sel_user;
  assign sel_idcode = (ir == IR_IDCODE);
  assign sel_user   = (ir == IR_USER);

  function automatic state_t next_state(input state_t cur, input logic m);
    case (cur)
      TLR:      return m ? TLR      : RTI;
      RTI:      return m ? SEL_DR   : RTI;
      SEL_DR:   return m ? SEL_IR   : CAP_DR;
      CAP_DR:   return m ? EX1_DR   : SH_DR;
      SH_DR:    return m ? EX1_DR   : SH_DR;
      EX1_DR:   return m ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return m ? EX2_DR   : PAUSE_DR;
      EX2_DR:   return m ? UPD_DR   : SH_DR;
      UPD_DR:   return m ? SEL_DR   : RTI;
      SEL_IR:   return m ? TLR      : CAP_IR;
      CAP_IR:   return m ? EX1_IR   : SH_IR;
      SH_IR:    return m ? EX1_IR   : SH_IR;
      EX1_IR:   return m ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return m ? EX2_IR   : PAUSE_IR;
      EX2_IR:   return m ? UPD_IR   : SH_IR;
      UPD_IR:   return m ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction

  always_ff @(posedge tck) begin
    if (!trst) begin
      state     <= TLR;
      ir        <= IR_IDCODE;
      ir_sr     <= '0;
      bypass_sr <= 1'b0;
      id_sr     <= '0;
      user_sr   <= '0;
      user_reg  <= '0;
    end else begin
      state <= next_state(state, tms);
      case (state)
        TLR:    ir <= IR_IDCODE;
        CAP_IR: ir_sr <= IR_IDCODE;
        SH_IR:  ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
        UPD_IR: ir <= ir_sr;
        CAP_DR: begin
          if (sel_idcode)    id_sr     <= IDCODE_VAL;
          else if (sel_user) user_sr   <= user_reg;
          else               bypass_sr <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode)    id_sr     <= {tdi, id_sr[31:1]};
          else if (sel_user) user_sr   <= {tdi, user_sr[USER_WIDTH-1:1]};
          else               bypass_sr <= tdi;
        end
        UPD_DR: if (sel_user) user_reg <= user_sr;
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo = 1'b0;
    case (state)
      SH_IR: tdo = ir_sr[0];
      SH_DR: begin
        if (sel_idcode)    tdo = id_sr[0];
        else if (sel_user) tdo = user_sr[0];
        else               tdo = bypass_sr;
      end
      default: tdo = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_jtag_tap_slave.sv
// tb_jtag_tap_slave
// Directed bench for jtag_tap_slave. Inputs change on the falling edge of
// tck; tdo is sampled at the same falling edge, i.e. the value the master
// sees at the following rising edge.
module tb_jtag_tap_slave;

  logic tck;
  logic trst;
  logic tdi;
  logic tms;
  logic tdo;

  int n_checks;
  int n_pass;

  jtag_tap_slave dut (
    .tck  (tck),
    .trst (trst),
    .tdi  (tdi),
    .tms  (tms),
    .tdo  (tdo)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic step(input logic m, input logic d, output logic b);
    @(negedge tck);
    tms = m;
    tdi = d;
    b   = tdo;
    @(posedge tck);
  endtask

  task automatic step_tms(input logic m);
    logic b;
    step(m, 1'b0, b);
  endtask

  task automatic pulse_trst();
    @(negedge tck);
    trst = 1'b0;
    tms  = 1'b0;
    @(posedge tck);
    @(negedge tck);
    trst = 1'b1;
  endtask

  // From Shift-DR: shift n bits, leaving via Exit1-DR on the last one.
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < n; i++) begin
      step((i == n - 1), din[i], b);
      dout[i] = b;
    end
  endtask

  // Exit1 -> Update -> Run-Test/Idle
  task automatic exit_to_rti();
    step_tms(1'b1);
    step_tms(1'b0);
  endtask

  task automatic rti_to_shdr();
    step_tms(1'b1);
    step_tms(1'b0);
    step_tms(1'b0);
  endtask

  task automatic tlr_to_shdr();
    step_tms(1'b0);
    rti_to_shdr();
  endtask

  task automatic five_ones();
    for (int i = 0; i < 5; i++) step_tms(1'b1);
  endtask

  // From RTI: load an instruction, return the bits seen on tdo, end in RTI.
  task automatic load_ir(input logic [3:0] code, output logic [3:0] cap);
    logic b;
    step_tms(1'b1);
    step_tms(1'b1);
    step_tms(1'b0);
    step_tms(1'b0);
    for (int i = 0; i < 4; i++) begin
      step((i == 3), code[i], b);
      cap[i] = b;
    end
    exit_to_rti();
  endtask

  // From TLR: read the default IDCODE register, end in RTI.
  task automatic read_idcode(input string tag);
    logic [31:0] d;
    tlr_to_shdr();
    shift_dr(32, 32'h0, d);
    chk(tag, d, 32'h1234_5001);
    exit_to_rti();
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  c;
    logic        b;
    n_checks = 0;
    n_pass   = 0;
    trst = 1'b0;
    tms  = 1'b1;
    tdi  = 1'b0;

    pulse_trst();
    chk("rst_tdo", {31'b0, tdo}, 32'h0);

    read_idcode("idcode_default");

    // Leave TLR to TLR from Shift-DR with IR set to BYPASS first.
    load_ir(4'b1111, c);
    rti_to_shdr();
    five_ones();
    @(negedge tck);
    chk("tlr_from_shdr_tdo", {31'b0, tdo}, 32'h0);
    read_idcode("tlr_from_shdr");

    // From Pause-IR
    step_tms(1'b1);
    step_tms(1'b1);
    step_tms(1'b0);
    step_tms(1'b0);
    step_tms(1'b1);
    step_tms(1'b0);
    five_ones();
    read_idcode("tlr_from_pauseir");

    // From Update-DR
    rti_to_shdr();
    step_tms(1'b1);
    step_tms(1'b1);
    five_ones();
    read_idcode("tlr_from_upddr");

    // BYPASS: capture bits 1,0,0,0 then one-edge echo of tdi.
    load_ir(4'b1111, c);
    chk("ir_capture", {28'b0, c}, 32'h1);
    rti_to_shdr();
    shift_dr(4, 32'b1101, d);
    chk("bypass_echo", d, 32'b1010);
    exit_to_rti();

    // USER write then read-back.
    load_ir(4'b0010, c);
    chk("ir_capture_user", {28'b0, c}, 32'h1);
    rti_to_shdr();
    shift_dr(32, 32'hA5A5_0F0F, d);
    chk("user_initial", d, 32'h0);
    exit_to_rti();
    rti_to_shdr();
    shift_dr(32, 32'h0, d);
    chk("user_readback", d, 32'hA5A5_0F0F);
    exit_to_rti();

    // Undefined code behaves as BYPASS.
    load_ir(4'b0111, c);
    rti_to_shdr();
    shift_dr(4, 32'b1011, d);
    chk("undef_bypass", d, 32'b0110);
    exit_to_rti();

    // trst in the middle of a USER shift.
    load_ir(4'b0010, c);
    rti_to_shdr();
    shift_dr(32, 32'hDEAD_BEEF, d);
    exit_to_rti();
    rti_to_shdr();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, b);
    pulse_trst();
    chk("trst_tdo", {31'b0, tdo}, 32'h0);
    read_idcode("trst_ir_idcode");
    load_ir(4'b0010, c);
    rti_to_shdr();
    shift_dr(32, 32'h0, d);
    chk("trst_user_cleared", d, 32'h0);
    exit_to_rti();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
